// File: rtl/mfp_input_debounce.sv
// mfp_input_debounce
// Input conditioning for the Nexys4 DDR pushbuttons and slide switches.
// Each raw input goes through a two-flop synchroniser into HCLK. Its level is
// accepted only after STABLE_TICKS consecutive prescaler ticks sample the
// same new value. The pushbuttons also get registered one-cycle rise and fall
// pulses that line up with the first cycle showing the new debounced level.
module mfp_input_debounce #(
    parameter int N_PB         = 6,
    parameter int N_SW         = 16,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic [N_PB-1:0] pbtn_in,
    input  logic [N_SW-1:0] switch_in,
    output logic [N_PB-1:0] pbtn_db,
    output logic [N_SW-1:0] swtch_db,
    output logic [N_PB-1:0] pbtn_rise,
    output logic [N_PB-1:0] pbtn_fall
);

    // Pushbuttons occupy the low bits of the combined bus, switches the high bits.
    localparam int N  = N_PB + N_SW;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS) + 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [N-1:0]    meta_q;
    logic [N-1:0]    sync_q;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic            tick;
    logic [CW-1:0]   cnt_q [N];
    logic [CW-1:0]   cnt_d [N];
    logic [N-1:0]    db_q;
    logic [N-1:0]    db_d;
    logic [N_PB-1:0] rise_q;
    logic [N_PB-1:0] rise_d;
    logic [N_PB-1:0] fall_q;
    logic [N_PB-1:0] fall_d;

    // Two-flop synchroniser for every asynchronous input bit.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {switch_in, pbtn_in};
            sync_q <= meta_q;
        end
    end

    // Prescaler next state: wraps at TICK_DIV-1. With TICK_DIV=1 it stays at 0 so tick is constant high.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Per-bit stability counters. A sample that matches the current level restarts the count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync_q[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = sync_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Edge pulses are registered together with db so they coincide with the new level.
    always_comb begin
        rise_d = db_d[N_PB-1:0] & ~db_q[N_PB-1:0];
        fall_d = ~db_d[N_PB-1:0] & db_q[N_PB-1:0];
    end

    // State registers; reset clears everything, including a count in progress.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            presc_q <= '0;
            db_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pbtn_db   = db_q[N_PB-1:0];
    assign swtch_db  = db_q[N-1:N_PB];
    assign pbtn_rise = rise_q;
    assign pbtn_fall = fall_q;

endmodule

// File: tb/tb_mfp_input_debounce.sv
// Testbench for mfp_input_debounce.
// Instance A uses TICK_DIV=4, STABLE_TICKS=3 and is checked every cycle against a
// sample-window reference model. Instance B uses TICK_DIV=1, STABLE_TICKS=1 and
// gets a directed exact-latency test.
module tb_mfp_input_debounce;

    localparam int A_TD = 4;
    localparam int A_ST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  pb_a;
    logic [15:0] sw_a;
    logic [5:0]  pb_b;
    logic [15:0] sw_b;

    logic [5:0]  pbtn_db_a, pbtn_rise_a, pbtn_fall_a;
    logic [15:0] swtch_db_a;
    logic [5:0]  pbtn_db_b, pbtn_rise_b, pbtn_fall_b;
    logic [15:0] swtch_db_b;

    mfp_input_debounce #(.N_PB(6), .N_SW(16), .TICK_DIV(A_TD), .STABLE_TICKS(A_ST)) dut_a (
        .HCLK(clk), .HRESET(rst), .pbtn_in(pb_a), .switch_in(sw_a),
        .pbtn_db(pbtn_db_a), .swtch_db(swtch_db_a), .pbtn_rise(pbtn_rise_a), .pbtn_fall(pbtn_fall_a)
    );

    mfp_input_debounce #(.N_PB(6), .N_SW(16), .TICK_DIV(1), .STABLE_TICKS(1)) dut_b (
        .HCLK(clk), .HRESET(rst), .pbtn_in(pb_b), .switch_in(sw_b),
        .pbtn_db(pbtn_db_b), .swtch_db(swtch_db_b), .pbtn_rise(pbtn_rise_b), .pbtn_fall(pbtn_fall_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model for instance A: the synced level is the raw level from two
    // edges back; a tick happens on every TICK_DIV-th edge after reset; a bit
    // flips when its last STABLE_TICKS tick samples all disagree with it.
    logic [21:0] rawq[$];
    logic [21:0] tickq[$];
    int          k;
    logic [21:0] mdb;
    logic [5:0]  mrise, mfall;

    task automatic model_step();
        logic [21:0] s;
        logic [21:0] nd;
        bit          all_diff;
        if (rst) begin
            rawq.delete();
            tickq.delete();
            k     = 0;
            mdb   = '0;
            mrise = '0;
            mfall = '0;
        end else begin
            s  = (rawq.size() == 2) ? rawq[0] : '0;
            nd = mdb;
            if ((k % A_TD) == A_TD - 1) begin
                tickq.push_back(s);
                if (tickq.size() > A_ST) void'(tickq.pop_front());
                if (tickq.size() == A_ST) begin
                    for (int i = 0; i < 22; i++) begin
                        all_diff = 1'b1;
                        foreach (tickq[j]) if (tickq[j][i] == mdb[i]) all_diff = 1'b0;
                        if (all_diff) nd[i] = ~mdb[i];
                    end
                end
            end
            mrise = nd[5:0] & ~mdb[5:0];
            mfall = ~nd[5:0] & mdb[5:0];
            mdb   = nd;
            rawq.push_back({sw_a, pb_a});
            if (rawq.size() > 2) void'(rawq.pop_front());
            k++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_a", {pbtn_db_a, swtch_db_a, pbtn_rise_a, pbtn_fall_a},
              {mdb[5:0], mdb[21:6], mrise, mfall});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] sel(input int w);
        case (w)
            0:       return {10'd0, pbtn_db_a};
            1:       return swtch_db_a;
            2:       return {10'd0, pbtn_db_b};
            default: return swtch_db_b;
        endcase
    endfunction

    // Steps cycles until (selected bus & mask) == val; n = cycles taken, -1 on timeout.
    task automatic wait_for(input int w, input logic [15:0] mask, input logic [15:0] val, output int n);
        int c;
        bit hit;
        c   = 0;
        hit = 1'b0;
        while (!hit && c < 30) begin
            cycle();
            c++;
            hit = ((sel(w) & mask) == val);
        end
        n = hit ? c : -1;
    endtask

    typedef struct packed {
        logic [5:0]  pb;
        logic [15:0] sw;
        logic [7:0]  cycles;
        logic [5:0]  exp_pb;
        logic [15:0] exp_sw;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        logic [5:0] seen;
        int r;

        tbl[0] = '{pb: 6'b000000, sw: 16'h0000, cycles: 8'd4,  exp_pb: 6'b000000, exp_sw: 16'h0000};
        tbl[1] = '{pb: 6'b000001, sw: 16'h0000, cycles: 8'd16, exp_pb: 6'b000001, exp_sw: 16'h0000};
        tbl[2] = '{pb: 6'b000000, sw: 16'h0000, cycles: 8'd16, exp_pb: 6'b000000, exp_sw: 16'h0000};
        tbl[3] = '{pb: 6'b000000, sw: 16'hA5C3, cycles: 8'd16, exp_pb: 6'b000000, exp_sw: 16'hA5C3};
        tbl[4] = '{pb: 6'b000000, sw: 16'hA5C2, cycles: 8'd16, exp_pb: 6'b000000, exp_sw: 16'hA5C2};
        tbl[5] = '{pb: 6'b101000, sw: 16'hA5C2, cycles: 8'd16, exp_pb: 6'b101000, exp_sw: 16'hA5C2};
        tbl[6] = '{pb: 6'b000000, sw: 16'h0000, cycles: 8'd16, exp_pb: 6'b000000, exp_sw: 16'h0000};

        rst  = 1'b1;
        pb_a = '0; sw_a = '0; pb_b = '0; sw_b = '0;
        mdb  = '0; mrise = '0; mfall = '0; k = 0;

        // Reset state with inputs high: everything must read 0.
        pb_a = 6'h3F; sw_a = 16'hFFFF; pb_b = 6'h3F; sw_b = 16'hFFFF;
        do_reset();
        check("reset_a", {pbtn_db_a, swtch_db_a, pbtn_rise_a, pbtn_fall_a}, 64'd0);
        check("reset_b", {pbtn_db_b, swtch_db_b, pbtn_rise_b, pbtn_fall_b}, 64'd0);
        pb_a = '0; sw_a = '0; pb_b = '0; sw_b = '0;

        // Clean press and release.
        do_reset();
        pb_a = 6'b000001;
        wait_for(0, 16'h0001, 16'h0001, n);
        check("press_latency_in_11_14", (n >= 11 && n <= 14), 1);
        check("press_db", pbtn_db_a, 6'b000001);
        check("press_rise", pbtn_rise_a, 6'b000001);
        check("press_no_fall", pbtn_fall_a, 6'b000000);
        cycle();
        check("press_rise_one_cycle", pbtn_rise_a, 6'b000000);
        pb_a = 6'b000000;
        wait_for(0, 16'h0001, 16'h0000, n);
        check("release_latency_in_11_14", (n >= 11 && n <= 14), 1);
        check("release_fall", pbtn_fall_a, 6'b000001);
        check("release_no_rise", pbtn_rise_a, 6'b000000);
        cycle();
        check("release_fall_one_cycle", pbtn_fall_a, 6'b000000);

        // Bounce: the low gap is phased to cover a tick, so no run reaches 3 ticks.
        do_reset();
        cycle();
        seen = '0;
        pb_a = 6'b000010;
        repeat (6) begin cycle(); seen |= pbtn_db_a | pbtn_rise_a | pbtn_fall_a; end
        pb_a = 6'b000000;
        repeat (3) begin cycle(); seen |= pbtn_db_a | pbtn_rise_a | pbtn_fall_a; end
        pb_a = 6'b000010;
        repeat (6) begin cycle(); seen |= pbtn_db_a | pbtn_rise_a | pbtn_fall_a; end
        pb_a = 6'b000000;
        repeat (20) begin cycle(); seen |= pbtn_db_a | pbtn_rise_a | pbtn_fall_a; end
        check("bounce_rejected", seen, 6'b000000);

        // Switch bus: all bits must land on the same cycle.
        do_reset();
        sw_a = 16'hA5C3;
        wait_for(1, 16'hFFFF, 16'hA5C3, n);
        check("sw_latency_le_14", (n >= 11 && n <= 14), 1);
        sw_a = 16'hA5C2;
        wait_for(1, 16'hFFFF, 16'hA5C2, n);
        check("sw_bit0_clear_latency", (n >= 11 && n <= 14), 1);

        // Reset in the middle of a count.
        do_reset();
        pb_a = 6'b000100;
        repeat (8) cycle();
        check("midcount_not_yet", pbtn_db_a, 6'b000000);
        rst = 1'b1;
        cycle();
        check("midcount_reset_outputs", {pbtn_db_a, swtch_db_a, pbtn_rise_a, pbtn_fall_a}, 64'd0);
        rst = 1'b0;
        wait_for(0, 16'h0004, 16'h0004, n);
        check("midcount_full_latency", (n >= 11 && n <= 15), 1);
        check("midcount_rise", pbtn_rise_a, 6'b000100);
        cycle();
        check("midcount_rise_gone", pbtn_rise_a, 6'b000000);

        // Two buttons pressed together.
        do_reset();
        pb_a = 6'b101000;
        wait_for(0, 16'h003F, 16'h0028, n);
        check("simul_latency", (n >= 11 && n <= 14), 1);
        check("simul_rise", pbtn_rise_a, 6'b101000);
        cycle();
        check("simul_rise_gone", pbtn_rise_a, 6'b000000);
        pb_a = 6'b000000;
        repeat (16) cycle();

        // Instance B: TICK_DIV=1, STABLE_TICKS=1 -> exactly 3 cycles.
        do_reset();
        pb_b = 6'b000001;
        wait_for(2, 16'h0001, 16'h0001, n);
        check("b_press_latency", n, 3);
        check("b_rise", pbtn_rise_b, 6'b000001);
        cycle();
        check("b_rise_gone", pbtn_rise_b, 6'b000000);
        pb_b = 6'b000000;
        wait_for(2, 16'h0001, 16'h0000, n);
        check("b_release_latency", n, 3);
        check("b_fall", pbtn_fall_b, 6'b000001);
        sw_b = 16'h8001;
        wait_for(3, 16'hFFFF, 16'h8001, n);
        check("b_sw_latency", n, 3);

        // Table-driven vectors.
        do_reset();
        for (int v = 0; v < 7; v++) begin
            pb_a = tbl[v].pb;
            sw_a = tbl[v].sw;
            for (int c = 0; c < int'(tbl[v].cycles); c++) cycle();
            check($sformatf("tbl%0d_pb", v), pbtn_db_a, tbl[v].exp_pb);
            check($sformatf("tbl%0d_sw", v), swtch_db_a, tbl[v].exp_sw);
        end

        // Random stimulus: stable stretches, short glitches, occasional reset.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) pb_a = 6'($urandom);
            if (r < 2) sw_a = 16'($urandom);
            if (r >= 96) pb_a[$urandom_range(0, 5)] ^= 1'b1;
            if (r == 50) sw_a[$urandom_range(0, 15)] ^= 1'b1;
            rst = ($urandom_range(0, 799) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
